// File: rtl/spi_bus_arbiter_if.sv
// Controller-side bus of the SPI arbiter.
// Carries config/TX toward spi_controller and RX/ready back.
interface spi_bus_arbiter_if;
    logic [10:0] o_spi_config;
    logic [7:0]  o_spi_tx;
    logic        o_spi_tx_valid;
    logic [7:0]  i_spi_rx;
    logic        i_spi_rx_valid;
    logic        i_spi_ready;

    modport master (
        output o_spi_config,
        output o_spi_tx,
        output o_spi_tx_valid,
        input  i_spi_rx,
        input  i_spi_rx_valid,
        input  i_spi_ready
    );

    modport slave (
        input  o_spi_config,
        input  o_spi_tx,
        input  o_spi_tx_valid,
        output i_spi_rx,
        output i_spi_rx_valid,
        output i_spi_ready
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one spi_controller between N_REQ clients.
// Handles per-client chip select, config caching and byte sequencing.
module spi_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [10*N_REQ-1:0]  i_req_cfg,
    input  logic [8*N_REQ-1:0]   i_req_len,
    input  logic [8*N_REQ-1:0]   i_req_tx,
    output logic [N_REQ-1:0]     o_tx_ack,
    output logic [7:0]           o_rx,
    output logic [N_REQ-1:0]     o_rx_valid,
    output logic [N_REQ-1:0]     o_grant,
    output logic [N_REQ-1:0]     o_done,
    output logic [N_REQ-1:0]     o_cs_n,
    spi_bus_arbiter_if.master    spi
);

    localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SETUP_N = (CS_SETUP > 0) ? CS_SETUP : 1;
    localparam int HOLD_N  = (CS_HOLD > 0) ? CS_HOLD : 1;

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_N - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_N - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CONFIG   = 3'd1;
    localparam logic [2:0] S_CFG_WAIT = 3'd2;
    localparam logic [2:0] S_CS_SETUP = 3'd3;
    localparam logic [2:0] S_SEND     = 3'd4;
    localparam logic [2:0] S_WAIT_RX  = 3'd5;
    localparam logic [2:0] S_CS_HOLD  = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    win_q, win_d;
    logic [9:0]       cfg_q, cfg_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [9:0]       cache_q, cache_d;
    logic             cache_vld_q, cache_vld_d;
    logic [7:0]       tmr_q, tmr_d;
    logic             rxv_prev_q, rxv_prev_d;

    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] cs_n_q, cs_n_d;
    logic [N_REQ-1:0] tx_ack_q, tx_ack_d;
    logic [N_REQ-1:0] rx_valid_q, rx_valid_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [7:0]       rx_q, rx_d;
    logic [10:0]      spi_cfg_q, spi_cfg_d;
    logic [7:0]       spi_tx_q, spi_tx_d;
    logic             spi_txv_q, spi_txv_d;

    logic [9:0]       cfg_arr [N_REQ];
    logic [7:0]       len_arr [N_REQ];
    logic [7:0]       tx_arr  [N_REQ];

    logic             found_c;
    logic [IW-1:0]    pick_c;
    logic [IW:0]      sum_c;
    logic [IW-1:0]    cand_c;
    logic             rx_edge;

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Unpack the flat per-requester buses into indexable arrays
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            cfg_arr[k] = i_req_cfg[10*k +: 10];
            len_arr[k] = i_req_len[8*k +: 8];
            tx_arr[k]  = i_req_tx[8*k +: 8];
        end
    end

    // Round-robin pick: first request above the pointer, wrapping
    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        sum_c   = '0;
        cand_c  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            sum_c = {1'b0, ptr_q} + (IW+1)'(i);
            if (sum_c >= (IW+1)'(N_REQ)) begin
                sum_c = sum_c - (IW+1)'(N_REQ);
            end
            cand_c = sum_c[IW-1:0];
            if (!found_c && i_req[cand_c]) begin
                found_c = 1'b1;
                pick_c  = cand_c;
            end
        end
    end

    assign rx_edge = spi.i_spi_rx_valid & ~rxv_prev_q;

    // Transfer sequencer: next-state and registered-output values
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cfg_d       = cfg_q;
        cnt_d       = cnt_q;
        cache_d     = cache_q;
        cache_vld_d = cache_vld_q;
        tmr_d       = tmr_q;
        rxv_prev_d  = spi.i_spi_rx_valid;
        grant_d     = grant_q;
        cs_n_d      = cs_n_q;
        rx_d        = rx_q;
        spi_cfg_d   = spi_cfg_q;
        spi_tx_d    = spi_tx_q;
        tx_ack_d    = '0;
        rx_valid_d  = '0;
        done_d      = '0;
        spi_txv_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (spi.i_spi_ready && found_c) begin
                    win_d   = pick_c;
                    ptr_d   = pick_c;
                    cfg_d   = cfg_arr[pick_c];
                    cnt_d   = len_arr[pick_c];
                    grant_d = onehot(pick_c);
                    tmr_d   = '0;
                    if (cache_vld_q && cfg_arr[pick_c] == cache_q) begin
                        cs_n_d  = ~onehot(pick_c);
                        state_d = S_CS_SETUP;
                    end else begin
                        state_d = S_CONFIG;
                    end
                end
            end
            S_CONFIG: begin
                spi_cfg_d   = {cfg_q, 1'b1};
                cache_d     = cfg_q;
                cache_vld_d = 1'b1;
                tmr_d       = '0;
                state_d     = S_CFG_WAIT;
            end
            S_CFG_WAIT: begin
                spi_cfg_d[0] = 1'b0;
                if (tmr_q == 8'd1) begin
                    tmr_d   = '0;
                    cs_n_d  = ~onehot(win_q);
                    state_d = S_CS_SETUP;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            S_CS_SETUP: begin
                if (tmr_q == SETUP_LAST) begin
                    tmr_d   = '0;
                    state_d = S_SEND;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            S_SEND: begin
                if (spi.i_spi_ready) begin
                    spi_tx_d  = tx_arr[win_q];
                    spi_txv_d = 1'b1;
                    tx_ack_d  = onehot(win_q);
                    state_d   = S_WAIT_RX;
                end
            end
            S_WAIT_RX: begin
                if (rx_edge) begin
                    rx_d       = spi.i_spi_rx;
                    rx_valid_d = onehot(win_q);
                    if (cnt_q == 8'd0) begin
                        tmr_d   = '0;
                        state_d = S_CS_HOLD;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        state_d = S_SEND;
                    end
                end
            end
            S_CS_HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    tmr_d   = '0;
                    cs_n_d  = '1;
                    done_d  = onehot(win_q);
                    grant_d = '0;
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= IW'(N_REQ - 1);
            win_q       <= '0;
            cfg_q       <= '0;
            cnt_q       <= '0;
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
            tmr_q       <= '0;
            rxv_prev_q  <= 1'b0;
            grant_q     <= '0;
            cs_n_q      <= '1;
            tx_ack_q    <= '0;
            rx_valid_q  <= '0;
            done_q      <= '0;
            rx_q        <= '0;
            spi_cfg_q   <= '0;
            spi_tx_q    <= '0;
            spi_txv_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cfg_q       <= cfg_d;
            cnt_q       <= cnt_d;
            cache_q     <= cache_d;
            cache_vld_q <= cache_vld_d;
            tmr_q       <= tmr_d;
            rxv_prev_q  <= rxv_prev_d;
            grant_q     <= grant_d;
            cs_n_q      <= cs_n_d;
            tx_ack_q    <= tx_ack_d;
            rx_valid_q  <= rx_valid_d;
            done_q      <= done_d;
            rx_q        <= rx_d;
            spi_cfg_q   <= spi_cfg_d;
            spi_tx_q    <= spi_tx_d;
            spi_txv_q   <= spi_txv_d;
        end
    end

    assign o_tx_ack           = tx_ack_q;
    assign o_rx               = rx_q;
    assign o_rx_valid         = rx_valid_q;
    assign o_grant            = grant_q;
    assign o_done             = done_q;
    assign o_cs_n             = cs_n_q;
    assign spi.o_spi_config   = spi_cfg_q;
    assign spi.o_spi_tx       = spi_tx_q;
    assign spi.o_spi_tx_valid = spi_txv_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a loopback controller model.
// Table-driven transfers plus hand-written reset and drop sequences.
module tb_spi_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [39:0] req_cfg;
    logic [31:0] req_len;
    logic [31:0] req_tx;
    logic [3:0]  o_tx_ack;
    logic [7:0]  o_rx;
    logic [3:0]  o_rx_valid;
    logic [3:0]  o_grant;
    logic [3:0]  o_done;
    logic [3:0]  o_cs_n;

    spi_bus_arbiter_if bus();

    spi_bus_arbiter #(.N_REQ(4), .CS_SETUP(2), .CS_HOLD(2)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_req_cfg  (req_cfg),
        .i_req_len  (req_len),
        .i_req_tx   (req_tx),
        .o_tx_ack   (o_tx_ack),
        .o_rx       (o_rx),
        .o_rx_valid (o_rx_valid),
        .o_grant    (o_grant),
        .o_done     (o_done),
        .o_cs_n     (o_cs_n),
        .spi        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        int          who;
        logic [9:0]  cfg;
        logic [7:0]  len;
        logic [7:0]  base;
        logic [7:0]  step;
        logic [3:0]  exp_done;
        bit          exp_cfg;
        logic [10:0] exp_cfg_val;
        int          exp_bytes;
        bit          hold;
        bit          drop;
    } vec_t;

    vec_t tbl [12];

    logic [9:0]  cfg_a  [4];
    logic [7:0]  len_a  [4];
    logic [7:0]  base_a [4];
    logic [7:0]  step_a [4];
    logic [7:0]  idx_a  [4];
    logic [7:0]  rxn_a  [4];

    int n_cmp, n_err;
    int n_cfg, n_txv, n_ack, n_rxv, n_done, n_ovl, n_proto;
    int cs_low, lead, cur_who, mcnt;
    bit lead_pend;
    logic [10:0] cfg_val;
    logic [3:0]  done_now;
    logic [7:0]  msh;

    always_comb begin
        req_cfg = '0;
        req_len = '0;
        req_tx  = '0;
        for (int k = 0; k < 4; k++) begin
            req_cfg[10*k +: 10] = cfg_a[k];
            req_len[8*k +: 8]   = len_a[k];
            req_tx[8*k +: 8]    = 8'(base_a[k] + idx_a[k] * step_a[k]);
        end
    end

    function automatic logic [3:0] oh(input int k);
        oh = 4'(1) << k;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] eb;
        @(negedge clk);
        done_now = o_done;
        if (!rst) begin
            if (bus.o_spi_config[0]) begin
                n_cfg++;
                cfg_val = bus.o_spi_config;
            end
            if (lead_pend) begin
                if (bus.o_spi_tx_valid) begin
                    lead      = cs_low;
                    lead_pend = 1'b0;
                end else if (o_cs_n != 4'hF) begin
                    cs_low++;
                end
            end
            if (bus.o_spi_tx_valid) n_txv++;
            if ($countones(~o_cs_n) > 1) n_ovl++;
            if (o_tx_ack != 4'h0) begin
                n_ack++;
                check("ack_owner", 32'(o_tx_ack), 32'(oh(cur_who)));
                idx_a[cur_who] = idx_a[cur_who] + 8'd1;
            end
            if (o_rx_valid != 4'h0) begin
                n_rxv++;
                check("rx_owner", 32'(o_rx_valid), 32'(oh(cur_who)));
                eb = 8'(base_a[cur_who] + rxn_a[cur_who] * step_a[cur_who]);
                check("rx_data", 32'(o_rx), 32'(eb));
                rxn_a[cur_who] = rxn_a[cur_who] + 8'd1;
            end
            if (o_done != 4'h0) n_done++;
        end
        if (rst) begin
            bus.i_spi_ready    = 1'b1;
            bus.i_spi_rx_valid = 1'b0;
            bus.i_spi_rx       = 8'h00;
            mcnt               = 0;
        end else if (bus.o_spi_tx_valid) begin
            if (mcnt != 0) n_proto++;
            msh             = bus.o_spi_tx;
            mcnt            = 4;
            bus.i_spi_ready = 1'b0;
        end else if (mcnt != 0) begin
            mcnt--;
            if (mcnt == 3) bus.i_spi_rx_valid = 1'b0;
            if (mcnt == 0) begin
                bus.i_spi_rx       = msh;
                bus.i_spi_rx_valid = 1'b1;
                bus.i_spi_ready    = 1'b1;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_grant"}, 32'(o_grant), 32'h0);
        check({tag, "_cs_n"}, 32'(o_cs_n), 32'hF);
        check({tag, "_tx_ack"}, 32'(o_tx_ack), 32'h0);
        check({tag, "_rx_valid"}, 32'(o_rx_valid), 32'h0);
        check({tag, "_done"}, 32'(o_done), 32'h0);
        check({tag, "_rx"}, 32'(o_rx), 32'h0);
        check({tag, "_config"}, 32'(bus.o_spi_config), 32'h0);
        check({tag, "_tx"}, 32'(bus.o_spi_tx), 32'h0);
        check({tag, "_tx_valid"}, 32'(bus.o_spi_tx_valid), 32'h0);
    endtask

    task automatic run_entry(input vec_t v, input int id);
        int c0, t0, a0, r0;
        bit got, dropped;
        string p;
        p  = $sformatf("v%0d", id);
        c0 = n_cfg;
        t0 = n_txv;
        a0 = n_ack;
        r0 = n_rxv;
        cfg_a[v.who]  = v.cfg;
        len_a[v.who]  = v.len;
        base_a[v.who] = v.base;
        step_a[v.who] = v.step;
        idx_a[v.who]  = 8'd0;
        rxn_a[v.who]  = 8'd0;
        cur_who   = v.who;
        cs_low    = 0;
        lead      = -1;
        lead_pend = 1'b1;
        req       = v.mask;
        got       = 1'b0;
        dropped   = 1'b0;
        for (int t = 0; t < 2000 && !got; t++) begin
            tick();
            if (v.drop && !dropped && n_ack > a0) begin
                req[v.who]   = 1'b0;
                len_a[v.who] = 8'd0;
                cfg_a[v.who] = 10'h3FF;
                dropped      = 1'b1;
            end
            if (done_now != 4'h0) got = 1'b1;
        end
        check({p, "_done_seen"}, 32'(got), 32'h1);
        if (got) begin
            check({p, "_done"}, 32'(done_now), 32'(v.exp_done));
            check({p, "_cs_released"}, 32'(o_cs_n), 32'hF);
            check({p, "_cfg_pulses"}, 32'(n_cfg - c0), 32'(v.exp_cfg));
            if (v.exp_cfg) begin
                check({p, "_cfg_val"}, 32'(cfg_val), 32'(v.exp_cfg_val));
            end
            check({p, "_tx_valids"}, 32'(n_txv - t0), 32'(v.exp_bytes));
            check({p, "_tx_acks"}, 32'(n_ack - a0), 32'(v.exp_bytes));
            check({p, "_rx_valids"}, 32'(n_rxv - r0), 32'(v.exp_bytes));
            check({p, "_cs_lead"}, 32'(lead >= 2), 32'h1);
        end
        if (!v.hold) req = 4'h0;
    endtask

    initial begin
        int a0, d0;
        bit reached;
        rst       = 1'b1;
        req       = 4'h0;
        n_cmp     = 0;
        n_err     = 0;
        n_cfg     = 0;
        n_txv     = 0;
        n_ack     = 0;
        n_rxv     = 0;
        n_done    = 0;
        n_ovl     = 0;
        n_proto   = 0;
        cs_low    = 0;
        lead      = -1;
        lead_pend = 1'b0;
        cur_who   = 0;
        mcnt      = 0;
        msh       = 8'h00;
        cfg_val   = '0;
        done_now  = '0;
        bus.i_spi_ready    = 1'b1;
        bus.i_spi_rx_valid = 1'b0;
        bus.i_spi_rx       = 8'h00;
        for (int k = 0; k < 4; k++) begin
            cfg_a[k]  = '0;
            len_a[k]  = '0;
            base_a[k] = '0;
            step_a[k] = '0;
            idx_a[k]  = '0;
            rxn_a[k]  = '0;
        end

        tbl[0]  = '{4'b0001, 0, 10'h010, 8'd0, 8'hA5, 8'h00, 4'b0001, 1'b1, 11'h021, 1, 1'b0, 1'b0};
        tbl[1]  = '{4'b0100, 2, 10'h020, 8'd3, 8'h11, 8'h11, 4'b0100, 1'b1, 11'h041, 4, 1'b0, 1'b0};
        tbl[2]  = '{4'b0100, 2, 10'h020, 8'd3, 8'h11, 8'h11, 4'b0100, 1'b0, 11'h000, 4, 1'b0, 1'b0};
        tbl[3]  = '{4'b0010, 1, 10'h00B, 8'd1, 8'h3C, 8'h01, 4'b0010, 1'b1, 11'h017, 2, 1'b0, 1'b0};
        tbl[4]  = '{4'b1000, 3, 10'h009, 8'd0, 8'h5A, 8'h00, 4'b1000, 1'b1, 11'h013, 1, 1'b0, 1'b0};
        tbl[5]  = '{4'b1111, 0, 10'h010, 8'd0, 8'hA5, 8'h00, 4'b0001, 1'b1, 11'h021, 1, 1'b1, 1'b0};
        tbl[6]  = '{4'b1111, 1, 10'h00B, 8'd1, 8'h3C, 8'h01, 4'b0010, 1'b1, 11'h017, 2, 1'b1, 1'b0};
        tbl[7]  = '{4'b1111, 2, 10'h020, 8'd3, 8'h11, 8'h11, 4'b0100, 1'b1, 11'h041, 4, 1'b1, 1'b0};
        tbl[8]  = '{4'b1111, 3, 10'h009, 8'd0, 8'h5A, 8'h00, 4'b1000, 1'b1, 11'h013, 1, 1'b1, 1'b0};
        tbl[9]  = '{4'b1111, 0, 10'h010, 8'd0, 8'hA5, 8'h00, 4'b0001, 1'b1, 11'h021, 1, 1'b0, 1'b0};
        tbl[10] = '{4'b0001, 0, 10'h010, 8'd2, 8'h70, 8'h01, 4'b0001, 1'b0, 11'h000, 3, 1'b0, 1'b1};
        tbl[11] = '{4'b1001, 0, 10'h010, 8'd0, 8'hC3, 8'h00, 4'b0001, 1'b1, 11'h021, 1, 1'b0, 1'b0};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset("rst");

        for (int i = 0; i <= 10; i++) begin
            run_entry(tbl[i], i);
        end

        cfg_a[0]  = 10'h010;
        len_a[0]  = 8'd3;
        base_a[0] = 8'h90;
        step_a[0] = 8'h01;
        idx_a[0]  = 8'd0;
        rxn_a[0]  = 8'd0;
        cur_who   = 0;
        lead_pend = 1'b0;
        a0        = n_ack;
        d0        = n_done;
        reached   = 1'b0;
        req       = 4'b0001;
        for (int t = 0; t < 2000 && !reached; t++) begin
            tick();
            if (n_ack - a0 == 2) reached = 1'b1;
        end
        check("mr_reach_byte2", 32'(reached), 32'h1);
        rst = 1'b1;
        tick();
        check_reset("mr");
        rst = 1'b0;
        req = 4'h0;
        repeat (10) tick();
        check("mr_no_done", 32'(n_done - d0), 32'h0);

        run_entry(tbl[11], 11);

        check("cs_overlap", 32'(n_ovl), 32'h0);
        check("tx_double", 32'(n_proto), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
